// File: rtl/hex_display_scanner.sv
// Time-multiplexed hex digit scanner feeding a 7-segment decoder: refresh timing,
// anti-ghost blanking, tear-free updates, leading-zero suppression and blink.
module hex_display_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_GAP    = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    load_i,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic                    lz_blank_en_i,
  input  logic [NUM_DIGITS-1:0]   blink_mask_i,
  output logic [3:0]              nibble_o,
  output logic [NUM_DIGITS-1:0]   digit_en_o,
  output logic                    blank_o,
  output logic                    frame_done_o
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GAP_C    = CW'(BLANK_GAP);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);

  // cnt_q/idx_q name the slot position whose outputs are produced at the next edge
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [FW-1:0]         frame_cnt_q, frame_cnt_d;
  logic                  phase_q, phase_d;
  logic [DW-1:0]         display_q, display_d;
  logic [DW-1:0]         pending_q, pending_d;
  logic                  pend_flag_q, pend_flag_d;
  logic [3:0]            nibble_d;
  logic [NUM_DIGITS-1:0] digit_en_d;
  logic                  blank_d;
  logic                  frame_done_d;

  logic                  frame_start_s;
  logic                  frame_end_s;
  logic                  zero_run_s;
  logic [NUM_DIGITS-1:0] lz_sup_s;
  logic [NUM_DIGITS-1:0] onehot_s;
  logic                  sup_s;

  assign frame_start_s = (cnt_q == '0) && (idx_q == '0);
  assign frame_end_s   = (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);

  // Slot position and blink timing
  always_comb begin
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    frame_cnt_d = frame_cnt_q;
    phase_d     = phase_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    if (frame_end_s) begin
      if (frame_cnt_q == FRM_LAST) begin
        frame_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FW'(1);
      end
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
  end

  // Double-buffered value: a load on the boundary edge bypasses the pending reg
  always_comb begin
    display_d   = display_q;
    pending_d   = pending_q;
    pend_flag_d = pend_flag_q;
    if (frame_start_s) begin
      if (load_i) begin
        display_d   = value_i;
        pend_flag_d = 1'b0;
      end else if (pend_flag_q) begin
        display_d   = pending_q;
        pend_flag_d = 1'b0;
      end else begin
        display_d   = display_q;
      end
    end else if (load_i) begin
      pending_d   = value_i;
      pend_flag_d = 1'b1;
    end else begin
      pending_d   = pending_q;
    end
  end

  // Suppression and next output values, evaluated on the display of this slot
  always_comb begin
    zero_run_s = 1'b1;
    lz_sup_s   = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run_s  = zero_run_s & (display_d[4*i +: 4] == 4'h0);
      lz_sup_s[i] = (i > 0) && zero_run_s;
    end
    onehot_s        = '0;
    onehot_s[idx_q] = 1'b1;
    sup_s = (lz_blank_en_i && lz_sup_s[idx_q]) || (phase_q && blink_mask_i[idx_q]);
    nibble_d = display_d[4*idx_q +: 4];
    if ((cnt_q < GAP_C) || sup_s) begin
      digit_en_d = '0;
    end else begin
      digit_en_d = onehot_s;
    end
    blank_d      = (digit_en_d == '0);
    frame_done_d = frame_end_s;
  end

  // State and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      frame_cnt_q  <= '0;
      phase_q      <= 1'b0;
      display_q    <= '0;
      pending_q    <= '0;
      pend_flag_q  <= 1'b0;
      nibble_o     <= 4'h0;
      digit_en_o   <= '0;
      blank_o      <= 1'b1;
      frame_done_o <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      frame_cnt_q  <= frame_cnt_d;
      phase_q      <= phase_d;
      display_q    <= display_d;
      pending_q    <= pending_d;
      pend_flag_q  <= pend_flag_d;
      nibble_o     <= nibble_d;
      digit_en_o   <= digit_en_d;
      blank_o      <= blank_d;
      frame_done_o <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Randomized bench for hex_display_scanner checked cycle by cycle against a
// frame/slot arithmetic model of the display behaviour.
module tb_hex_display_scanner;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int BG = 2;
  localparam int BF = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          load;
  logic [15:0]   value;
  logic          lz_en;
  logic [3:0]    mask;
  logic [3:0]    nibble;
  logic [3:0]    digit_en;
  logic          blank;
  logic          frame_done;

  int            n_vec = 0;
  int            n_err = 0;

  int            t;
  logic [15:0]   m_disp;
  logic [15:0]   m_pend;
  bit            m_flag;
  bit            m_fd;

  always #5 clk = ~clk;

  hex_display_scanner #(
    .NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_GAP(BG), .BLINK_FRAMES(BF)
  ) dut (
    .clk_i(clk), .rst_i(rst), .load_i(load), .value_i(value),
    .lz_blank_en_i(lz_en), .blink_mask_i(mask),
    .nibble_o(nibble), .digit_en_o(digit_en), .blank_o(blank),
    .frame_done_o(frame_done)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0d, time %0t)", tag, obs, exp, t, $time);
    end
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    load = 1'b0;
    #1;
    check_val("rst_nibble", 32'(nibble), 32'h0);
    check_val("rst_digit_en", 32'(digit_en), 32'h0);
    check_val("rst_blank", 32'(blank), 32'h1);
    check_val("rst_frame_done", 32'(frame_done), 32'h0);
    #1;
    rst    = 1'b0;
    t      = 0;
    m_disp = 16'h0;
    m_pend = 16'h0;
    m_flag = 1'b0;
    m_fd   = 1'b0;
  endtask

  // One clock: advance the model with the inputs present at the edge, then compare
  task automatic step();
    int         slot;
    int         cyc;
    int         frame;
    bit         phase;
    bit         sup;
    logic [3:0] e_en;
    logic [3:0] e_nib;
    @(posedge clk);
    if (t % (RD * ND) == 0) begin
      if (load) begin
        m_disp = value;
        m_flag = 1'b0;
      end else if (m_flag) begin
        m_disp = m_pend;
        m_flag = 1'b0;
      end
    end else if (load) begin
      m_pend = value;
      m_flag = 1'b1;
    end
    slot  = (t / RD) % ND;
    cyc   = t % RD;
    frame = t / (RD * ND);
    phase = ((frame / BF) % 2) == 1;
    sup   = (lz_en && slot > 0 && (m_disp >> (4 * slot)) == 16'h0) ||
            (phase && mask[slot]);
    e_nib = 4'((m_disp >> (4 * slot)) & 16'hF);
    e_en  = (cyc < BG || sup) ? 4'b0000 : 4'(1 << slot);
    m_fd  = (slot == ND - 1) && (cyc == RD - 1);
    t++;
    #1;
    check_val("nibble", 32'(nibble), 32'(e_nib));
    check_val("digit_en", 32'(digit_en), 32'(e_en));
    check_val("blank", 32'(blank), 32'(e_en == 4'b0000));
    check_val("frame_done", 32'(frame_done), 32'(m_fd));
  endtask

  task automatic pulse_load(input logic [15:0] v);
    load  = 1'b1;
    value = v;
    step();
    load  = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst   = 1'b1;
    load  = 1'b0;
    value = 16'h0;
    lz_en = 1'b0;
    mask  = 4'b0000;
    do_reset();

    pulse_load(16'h1A3F);
    run(63);
    while (t % (RD * ND) != RD + 2) step();
    pulse_load(16'h2222);
    run(70);

    pulse_load(16'h1A3F);
    while (t % (RD * ND) != RD + 1) step();
    pulse_load(16'h5555);
    while (t % (RD * ND) != 2 * RD + 3) step();
    #3;
    do_reset();
    run(40);

    lz_en = 1'b1;
    pulse_load(16'h0050);
    run(70);
    pulse_load(16'h0000);
    run(70);
    lz_en = 1'b0;

    for (int i = 0; i < 40 && !m_fd; i++) step();
    pulse_load(16'hBEEF);
    run(40);

    mask = 4'b0001;
    pulse_load(16'h1234);
    run(200);

    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 699) == 0) begin
        #2;
        do_reset();
      end
      if ($urandom_range(0, 99) == 0) lz_en = ~lz_en;
      if ($urandom_range(0, 149) == 0) mask = 4'($urandom);
      load  = ($urandom_range(0, 15) == 0) || (m_fd && $urandom_range(0, 1) == 1);
      value = 16'($urandom) >> (4 * $urandom_range(0, 4));
      step();
    end
    load = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
